// File: rtl/ramb16_s4_s1_fifo_ctrl.sv
// ramb16_s4_s1_fifo_ctrl
//
// Single-clock FIFO controller for an external X_RAMB16_S1_S4 block RAM.
// Nibbles enter on a valid/ready interface and are written through RAM
// port B (4 bits x 4096 words). Bits are fetched through port A
// (1 bit x 16384 words). They are presented LSB-first on a
// first-word-fall-through valid/ready interface.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   WR_VALID/WR_READY/WR_DATA  nibble input handshake
//   RD_VALID/RD_READY/RD_DATA  serial bit output handshake
//   COUNT, AFULL, AEMPTY     occupancy in bits (RAM + output pipeline), flags
//   ADDRB, DIB, ENB, WEB, SSRB         RAM port B (write side)
//   ADDRA, ENA, WEA, DIA, SSRA, DOA    RAM port A (read side)

module ramb16_s4_s1_fifo_ctrl #(
  parameter logic [14:0] AFULL_LEVEL  = 15'd16320,
  parameter logic [14:0] AEMPTY_LEVEL = 15'd16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [3:0]  WR_DATA,
  output logic        RD_VALID,
  input  logic        RD_READY,
  output logic        RD_DATA,
  output logic [14:0] COUNT,
  output logic        AFULL,
  output logic        AEMPTY,
  output logic [11:0] ADDRB,
  output logic [3:0]  DIB,
  output logic        ENB,
  output logic        WEB,
  output logic        SSRB,
  output logic [13:0] ADDRA,
  output logic        ENA,
  output logic        WEA,
  output logic        DIA,
  output logic        SSRA,
  input  logic        DOA
);

  // A nibble may be accepted only while at least four bit slots are free.
  localparam logic [14:0] WR_LIMIT = 15'd16380;

  logic [11:0] wp;
  logic [13:0] rp;
  logic [14:0] ram_bits;
  logic        inflight;
  logic [1:0]  buf_cnt;
  logic [1:0]  buf_bit;
  logic [14:0] count_q;
  logic        afull_q;
  logic        aempty_q;

  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  occ;
  logic        slot;
  logic [14:0] count_next;

  assign WR_READY = !RST && (count_q <= WR_LIMIT);
  assign push     = WR_VALID && WR_READY;
  assign RD_VALID = (buf_cnt != 2'd0);
  assign pop      = RD_VALID && RD_READY;

  // Output-pipeline occupancy after this cycle's pop. Keeping it below two
  // guarantees the skid buffer has room when the fetched bit lands.
  assign occ   = {2'b00, inflight} + {1'b0, buf_cnt} - {2'b00, pop};
  assign issue = !RST && (ram_bits != 15'd0) && (occ < 3'd2);

  // Buffer slot that receives DOA: the first free entry after the pop shift.
  assign slot = (buf_cnt == 2'd2) || ((buf_cnt == 2'd1) && !pop);

  assign count_next = count_q + (push ? 15'd4 : 15'd0) - (pop ? 15'd1 : 15'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp       <= '0;
      rp       <= '0;
      ram_bits <= '0;
      inflight <= 1'b0;
      buf_cnt  <= '0;
      buf_bit  <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (push) wp <= wp + 12'd1;
      if (issue) rp <= rp + 14'd1;
      ram_bits <= ram_bits + (push ? 15'd4 : 15'd0) - (issue ? 15'd1 : 15'd0);
      inflight <= issue;

      // Head is left untouched when the buffer empties, so RD_DATA keeps
      // its last value; a landing bit overrides the shift below.
      if (pop && (buf_cnt == 2'd2)) buf_bit[0] <= buf_bit[1];
      if (inflight) buf_bit[slot] <= DOA;
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};

      count_q  <= count_next;
      afull_q  <= (count_next >= AFULL_LEVEL);
      aempty_q <= (count_next <= AEMPTY_LEVEL);
    end
  end

  assign RD_DATA = buf_bit[0];
  assign COUNT   = count_q;
  assign AFULL   = afull_q;
  assign AEMPTY  = aempty_q;

  assign ADDRB = wp;
  assign DIB   = WR_DATA;
  assign ENB   = push;
  assign WEB   = push;
  assign SSRB  = 1'b0;

  // ENA together with SSRA during reset clears the RAM output latch.
  assign ADDRA = rp;
  assign ENA   = issue || RST;
  assign WEA   = 1'b0;
  assign DIA   = 1'b0;
  assign SSRA  = RST;

endmodule
